// File: rtl/sched_1r2wg_pkg.sv
// Shared types and helpers for the 1R2W client arbiter: read-return tag,
// round-robin pick result and pointer wrap arithmetic.
package sched_1r2wg_pkg;

    localparam int DEF_NUMCLNT = 4;
    localparam int DEF_BITCLNT = 2;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_BITADDR = 13;
    localparam int DEF_RD_LAT  = 2;

    typedef struct packed {
        logic                   vld;
        logic [DEF_BITCLNT-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                   found;
        logic [DEF_BITCLNT-1:0] idx;
    } pick_t;

    function automatic logic [DEF_BITCLNT-1:0] inc_wrap(input logic [DEF_BITCLNT-1:0] i);
        return (i == DEF_BITCLNT'(DEF_NUMCLNT - 1)) ? '0 : i + 1'b1;
    endfunction

    function automatic pick_t rr_first(input logic [DEF_NUMCLNT-1:0] req,
                                       input logic [DEF_BITCLNT-1:0] ptr);
        pick_t                  res;
        logic [DEF_BITCLNT-1:0] j;
        res = '0;
        j   = ptr;
        for (int k = 0; k < DEF_NUMCLNT; k++) begin
            if (!res.found && req[j]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
            j = inc_wrap(j);
        end
        return res;
    endfunction

endpackage

// File: rtl/sched_1r2wg_client_arb_rr_pick.sv
// Combinational round-robin search: first set request bit at or after ptr,
// wrapping modulo NUMCLNT.
module rr_pick_n #(
    parameter int NUMCLNT = 4,
    parameter int BITCLNT = 2
) (
    input  logic [NUMCLNT-1:0] req,
    input  logic [BITCLNT-1:0] ptr,
    output logic               found,
    output logic [BITCLNT-1:0] idx
);

    logic [BITCLNT-1:0] j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = ptr;
        for (int k = 0; k < NUMCLNT; k++) begin
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
            j = (j == BITCLNT'(NUMCLNT - 1)) ? '0 : j + 1'b1;
        end
    end

endmodule

// File: rtl/sched_1r2wg_client_arb.sv
// Shares one 1R2W memory macro between NUMCLNT clients: round-robin grants,
// registered issue, and a tag pipe that routes read returns back to the issuer.
module sched_1r2wg_client_arb
    import sched_1r2wg_pkg::*;
#(
    parameter int NUMCLNT = DEF_NUMCLNT,
    parameter int BITCLNT = DEF_BITCLNT,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BITADDR = DEF_BITADDR,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMCLNT-1:0]         cl_rd_req,
    input  logic [NUMCLNT*BITADDR-1:0] cl_rd_adr,
    output logic [NUMCLNT-1:0]         cl_rd_gnt,
    input  logic [NUMCLNT-1:0]         cl_wr_req,
    input  logic [NUMCLNT*BITADDR-1:0] cl_wr_adr,
    input  logic [NUMCLNT*WIDTH-1:0]   cl_wr_din,
    output logic [NUMCLNT-1:0]         cl_wr_gnt,
    output logic [NUMCLNT-1:0]         cl_rd_vld,
    output logic [WIDTH-1:0]           cl_rd_dout,
    output logic                       cl_rd_serr,
    output logic                       cl_rd_derr,
    output logic                       read,
    output logic [BITADDR-1:0]         rd_adr,
    output logic [1:0]                 write,
    output logic [2*BITADDR-1:0]       wr_adr,
    output logic [2*WIDTH-1:0]         din,
    input  logic                       ready,
    input  logic                       rd_vld,
    input  logic [WIDTH-1:0]           rd_dout,
    input  logic                       rd_serr,
    input  logic                       rd_derr,
    output logic                       err_orphan
);

    logic               arb_en;
    logic [NUMCLNT-1:0] rd_req_en;
    logic [NUMCLNT-1:0] wr_req_en;
    logic [NUMCLNT-1:0] wr_req_rest;
    logic               rd_found;
    logic               g0_found;
    logic               g1_found;
    logic               g1_ok;
    logic [BITCLNT-1:0] rd_idx;
    logic [BITCLNT-1:0] g0_idx;
    logic [BITCLNT-1:0] g1_idx;
    logic [BITCLNT-1:0] g1_ptr;
    logic [BITCLNT-1:0] rd_ptr;
    logic [BITCLNT-1:0] wr_ptr;
    logic [BITCLNT-1:0] rd_id;
    logic [BITADDR-1:0] g0_adr;
    logic [BITADDR-1:0] g1_adr;
    tag_t               tags [RD_LAT];
    tag_t               tail;

    assign arb_en    = ready & ~rst;
    assign rd_req_en = cl_rd_req & {NUMCLNT{arb_en}};
    assign wr_req_en = cl_wr_req & {NUMCLNT{arb_en}};

    rr_pick_n #(.NUMCLNT(NUMCLNT), .BITCLNT(BITCLNT)) u_rd_pick (
        .req   (rd_req_en),
        .ptr   (rd_ptr),
        .found (rd_found),
        .idx   (rd_idx)
    );

    rr_pick_n #(.NUMCLNT(NUMCLNT), .BITCLNT(BITCLNT)) u_wr_pick0 (
        .req   (wr_req_en),
        .ptr   (wr_ptr),
        .found (g0_found),
        .idx   (g0_idx)
    );

    // Nothing requests between wr_ptr and g0, so searching from g0+1 with g0
    // masked finds the next requester before wrapping back to wr_ptr.
    assign wr_req_rest = wr_req_en & ~(NUMCLNT'(1) << g0_idx);
    assign g1_ptr      = inc_wrap(g0_idx);

    rr_pick_n #(.NUMCLNT(NUMCLNT), .BITCLNT(BITCLNT)) u_wr_pick1 (
        .req   (wr_req_rest),
        .ptr   (g1_ptr),
        .found (g1_found),
        .idx   (g1_idx)
    );

    assign g0_adr = cl_wr_adr[g0_idx*BITADDR +: BITADDR];
    assign g1_adr = cl_wr_adr[g1_idx*BITADDR +: BITADDR];
    assign g1_ok  = g0_found & g1_found & (g1_adr != g0_adr);

    assign cl_rd_gnt = rd_found ? (NUMCLNT'(1) << rd_idx) : '0;
    assign cl_wr_gnt = (g0_found ? (NUMCLNT'(1) << g0_idx) : '0)
                     | (g1_ok    ? (NUMCLNT'(1) << g1_idx) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            read   <= 1'b0;
            rd_adr <= '0;
            rd_id  <= '0;
            rd_ptr <= '0;
        end else begin
            read <= rd_found;
            if (rd_found) begin
                rd_adr <= cl_rd_adr[rd_idx*BITADDR +: BITADDR];
                rd_id  <= rd_idx;
                rd_ptr <= inc_wrap(rd_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write  <= 2'b00;
            wr_adr <= '0;
            din    <= '0;
            wr_ptr <= '0;
        end else begin
            write <= {g1_ok, g0_found};
            if (g0_found) begin
                wr_adr[0 +: BITADDR] <= g0_adr;
                din[0 +: WIDTH]      <= cl_wr_din[g0_idx*WIDTH +: WIDTH];
            end
            if (g1_ok) begin
                wr_adr[BITADDR +: BITADDR] <= g1_adr;
                din[WIDTH +: WIDTH]        <= cl_wr_din[g1_idx*WIDTH +: WIDTH];
                wr_ptr                     <= inc_wrap(g1_idx);
            end else if (g0_found) begin
                wr_ptr <= inc_wrap(g0_idx);
            end
        end
    end

    // Tags trail the issued read so the tail lines up with the macro's rd_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '{vld: read, id: rd_id};
            for (int i = 1; i < RD_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign tail       = tags[RD_LAT-1];
    assign cl_rd_vld  = (rd_vld & tail.vld & ~rst) ? (NUMCLNT'(1) << tail.id) : '0;
    assign cl_rd_dout = rd_dout;
    assign cl_rd_serr = rd_serr;
    assign cl_rd_derr = rd_derr;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (rd_vld != tail.vld) begin
            err_orphan <= 1'b1;
        end
    end

endmodule
